// File: rtl/crc16_check.sv
// rtl/crc16_check.sv - receive-side CRC16 checker (x^16+x^15+x^2+1, init 0xFFFF)
module crc16_check #(
    parameter int LEN_W      = 16,
    parameter bit CRC_INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             runt,
    output logic [15:0]      calc_crc,
    output logic [15:0]      rx_crc,
    output logic [LEN_W-1:0] frame_len
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BODY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [15:0]      CRC_INIT = 16'hFFFF;
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    // Byte-parallel CRC step, MSB of the data byte first, same mapping as the crc16 generator.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    state_e           state_q;
    logic [15:0]      lfsr_q;
    logic [7:0]       h0_q;
    logic [7:0]       h1_q;
    logic [1:0]       cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             done_q;
    logic             ok_q;
    logic             err_q;
    logic             runt_q;
    logic [15:0]      calc_q;
    logic [15:0]      rx_q;

    logic             accept;
    logic [15:0]      lfsr_d;
    logic [15:0]      rx_d;
    logic [15:0]      expect_d;
    logic             match_d;
    logic [LEN_W-1:0] len_d;

    // Handshake and the next-state helpers used by the sequential block.
    always_comb begin
        accept   = in_valid && (state_q != S_DONE);
        lfsr_d   = crc16_next(lfsr_q, h1_q);
        rx_d     = {h0_q, in_data};
        expect_d = CRC_INVERT ? ~lfsr_d : lfsr_d;
        match_d  = (rx_d == expect_d);
        if (state_q == S_IDLE) begin
            len_d = LEN_ONE;
        end else if (len_q == {LEN_W{1'b1}}) begin
            len_d = len_q;
        end else begin
            len_d = len_q + LEN_ONE;
        end
    end

    // Frame FSM: two-byte delay line keeps the CRC bytes out of the lfsr; results captured on in_last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= CRC_INIT;
            h0_q    <= 8'h00;
            h1_q    <= 8'h00;
            cnt_q   <= 2'd0;
            len_q   <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            runt_q  <= 1'b0;
            calc_q  <= 16'h0000;
            rx_q    <= 16'h0000;
        end else begin
            case (state_q)
                S_IDLE, S_BODY: begin
                    if (accept) begin
                        len_q <= len_d;
                        if (in_last) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            rx_q    <= rx_d;
                            if (cnt_q == 2'd2) begin
                                calc_q <= lfsr_d;
                                ok_q   <= match_d;
                                err_q  <= !match_d;
                                runt_q <= 1'b0;
                            end else begin
                                calc_q <= CRC_INIT;
                                ok_q   <= 1'b0;
                                err_q  <= 1'b0;
                                runt_q <= 1'b1;
                            end
                        end else begin
                            state_q <= S_BODY;
                            if (cnt_q == 2'd2) begin
                                lfsr_q <= lfsr_d;
                            end else begin
                                cnt_q <= cnt_q + 2'd1;
                            end
                            h1_q <= h0_q;
                            h0_q <= in_data;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    lfsr_q  <= CRC_INIT;
                    cnt_q   <= 2'd0;
                    h0_q    <= 8'h00;
                    h1_q    <= 8'h00;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q != S_DONE);
    assign done      = done_q;
    assign crc_ok    = ok_q;
    assign crc_err   = err_q;
    assign runt      = runt_q;
    assign calc_crc  = calc_q;
    assign rx_crc    = rx_q;
    assign frame_len = len_q;

endmodule

// File: tb/tb_crc16_check.sv
// tb/tb_crc16_check.sv - directed self-checking bench for crc16_check
module tb_crc16_check;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;

    logic        rdy_a, done_a, ok_a, err_a, runt_a;
    logic [15:0] calc_a, rx_a;
    logic [15:0] len_a;
    logic        rdy_b, done_b, ok_b, err_b, runt_b;
    logic [15:0] calc_b, rx_b;
    logic [15:0] len_b;
    logic        rdy_c, done_c, ok_c, err_c, runt_c;
    logic [15:0] calc_c, rx_c;
    logic [1:0]  len_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    crc16_check #(.LEN_W(16), .CRC_INVERT(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_a), .done(done_a), .crc_ok(ok_a), .crc_err(err_a), .runt(runt_a),
        .calc_crc(calc_a), .rx_crc(rx_a), .frame_len(len_a)
    );

    crc16_check #(.LEN_W(16), .CRC_INVERT(1'b1)) u_inv (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_b), .done(done_b), .crc_ok(ok_b), .crc_err(err_b), .runt(runt_b),
        .calc_crc(calc_b), .rx_crc(rx_b), .frame_len(len_b)
    );

    crc16_check #(.LEN_W(2), .CRC_INVERT(1'b0)) u_sat (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy_c), .done(done_c), .crc_ok(ok_c), .crc_err(err_c), .runt(runt_c),
        .calc_crc(calc_c), .rx_crc(rx_c), .frame_len(len_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC: classic shift-register form, byte XORed into the top of the register.
    function automatic logic [15:0] ref_crc(input bq_t q);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[k]) begin
            c = c ^ {q[k], 8'h00};
            for (int b = 0; b < 8; b++) begin
                if (c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
                else       c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Called at a negedge; returns at the negedge after the last byte was accepted.
    task automatic send_frame(input bq_t q, input bit gaps);
        bit acc;
        int tries;
        foreach (q[k]) begin
            if (gaps && k > 0 && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_data  = q[k];
            in_last  = (k == q.size() - 1);
            in_valid = 1'b1;
            tries    = 0;
            acc      = 1'b0;
            while (!acc && tries < 8) begin
                acc = rdy_a;
                @(negedge clk);
                tries++;
            end
            if (!acc) chk("handshake_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        bq_t f;
        bq_t pay;
        logic [15:0] c;
        int ndone;

        rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("reset_ready", rdy_a, 1);
        chk("reset_done", done_a, 0);
        chk("reset_ok", ok_a, 0);
        chk("reset_calc", calc_a, 16'h0000);
        chk("reset_len", len_a, 0);
        rst = 1'b1;
        @(negedge clk);

        // in_last without in_valid must not end anything
        in_last = 1'b1;
        @(negedge clk);
        in_last = 1'b0;
        chk("last_no_valid_done", done_a, 0);
        chk("last_no_valid_ready", rdy_a, 1);

        // Test 1: passing 3-byte frame
        f = '{8'h00, 8'hFD, 8'h02};
        send_frame(f, 1'b0);
        chk("t1_done", done_a, 1);
        chk("t1_ready_low", rdy_a, 0);
        chk("t1_ok", ok_a, 1);
        chk("t1_err", err_a, 0);
        chk("t1_runt", runt_a, 0);
        chk("t1_calc", calc_a, 16'hFD02);
        chk("t1_rx", rx_a, 16'hFD02);
        chk("t1_len", len_a, 3);
        chk("t1_inv_err", err_b, 1);
        @(negedge clk);
        chk("t1_done_pulse", done_a, 0);
        chk("t1_ok_held", ok_a, 1);

        // Test 2: mismatch
        f = '{8'h00, 8'hFD, 8'h03};
        send_frame(f, 1'b0);
        chk("t2_ok", ok_a, 0);
        chk("t2_err", err_a, 1);
        chk("t2_calc", calc_a, 16'hFD02);
        chk("t2_rx", rx_a, 16'hFD03);
        @(negedge clk);

        // Test 3: runts of 1 and 2 bytes
        f = '{8'h55};
        send_frame(f, 1'b0);
        chk("t3a_done", done_a, 1);
        chk("t3a_runt", runt_a, 1);
        chk("t3a_ok", ok_a, 0);
        chk("t3a_err", err_a, 0);
        chk("t3a_calc", calc_a, 16'hFFFF);
        chk("t3a_rx", rx_a, 16'h0055);
        chk("t3a_len", len_a, 1);
        @(negedge clk);
        f = '{8'h12, 8'h34};
        send_frame(f, 1'b0);
        chk("t3b_runt", runt_a, 1);
        chk("t3b_len", len_a, 2);
        chk("t3b_rx", rx_a, 16'h1234);
        chk("t3b_calc", calc_a, 16'hFFFF);
        @(negedge clk);

        // Test 4: back-to-back, frame 2 offered during DONE, random gaps
        f = '{8'h00, 8'hFD, 8'h02};
        send_frame(f, 1'b0);
        chk("t4_f1_ok", ok_a, 1);
        chk("t4_ready_low_in_done", rdy_a, 0);
        pay.delete();
        for (int k = 0; k < 5; k++) pay.push_back(8'($urandom_range(0, 255)));
        c = ref_crc(pay);
        f = pay;
        f.push_back(c[15:8]);
        f.push_back(c[7:0]);
        send_frame(f, 1'b1);
        chk("t4_f2_done", done_a, 1);
        chk("t4_f2_ok", ok_a, 1);
        chk("t4_f2_calc", calc_a, c);
        chk("t4_f2_rx", rx_a, c);
        chk("t4_f2_len", len_a, 7);
        chk("t4_sat_len", len_c, 3);
        chk("t4_sat_ok", ok_c, 1);
        @(negedge clk);

        // Test 5: reset mid-frame
        in_data = 8'hA5; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("t5_rst_ready", rdy_a, 1);
        chk("t5_rst_ok", ok_a, 0);
        chk("t5_rst_rx", rx_a, 0);
        chk("t5_rst_len", len_a, 0);
        chk("t5_rst_calc", calc_a, 0);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        f = '{8'h00, 8'hFD, 8'h02};
        send_frame(f, 1'b0);
        chk("t5_after_ok", ok_a, 1);
        chk("t5_after_len", len_a, 3);
        @(negedge clk);

        // Test 6: inverted CRC comparison
        f = '{8'h00, 8'h02, 8'hFD};
        send_frame(f, 1'b0);
        chk("t6_inv_ok", ok_b, 1);
        chk("t6_inv_calc", calc_b, 16'hFD02);
        chk("t6_plain_err", err_a, 1);
        @(negedge clk);
        f = '{8'h00, 8'hFD, 8'h02};
        send_frame(f, 1'b0);
        chk("t6_inv_err", err_b, 1);
        chk("t6_inv_not_ok", ok_b, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
